// File: rtl/sram_req_executor_if.sv
// ---------------------------------------------------------------------------
// sram_req_executor_if
// Request/response handshake between the request crossing stage (master) and
// the SRAM request executor (slave). Everything here lives in the SRAM clock
// domain.
//   req_valid          master -> slave  request present
//   req_ready          slave  -> master executor idle, request taken on edge
//   req_base_read_ce   master -> slave  read base chip
//   req_base_write_ce  master -> slave  write base chip
//   req_ext_read_ce    master -> slave  read ext chip
//   req_ext_write_ce   master -> slave  write ext chip
//   req_addr_wdata_ce  master -> slave  {base addr, ext addr, base wdata, ext wdata}
//   resp_valid         slave  -> master one-cycle completion pulse
//   resp_base_rdata    slave  -> master last base read word
//   resp_ext_rdata     slave  -> master last ext read word
// ---------------------------------------------------------------------------
interface sram_req_executor_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_base_read_ce;
    logic         req_base_write_ce;
    logic         req_ext_read_ce;
    logic         req_ext_write_ce;
    logic [103:0] req_addr_wdata_ce;
    logic         resp_valid;
    logic [31:0]  resp_base_rdata;
    logic [31:0]  resp_ext_rdata;

    modport master (
        output req_valid, req_base_read_ce, req_base_write_ce,
               req_ext_read_ce, req_ext_write_ce, req_addr_wdata_ce,
        input  req_ready, resp_valid, resp_base_rdata, resp_ext_rdata
    );

    modport slave (
        input  req_valid, req_base_read_ce, req_base_write_ce,
               req_ext_read_ce, req_ext_write_ce, req_addr_wdata_ce,
        output req_ready, resp_valid, resp_base_rdata, resp_ext_rdata
    );
endinterface

// File: rtl/sram_req_executor.sv
// ---------------------------------------------------------------------------
// sram_req_executor
// Takes one packed request per handshake and runs the read and/or write
// timing on the base and ext asynchronous SRAM chips, then returns both read
// words with a one-cycle resp_valid pulse. Every SRAM pin is driven from a
// register, so nothing on req_* reaches the board combinationally.
// Ports:
//   clk, rst          SRAM clock, asynchronous active-high reset
//   req               request/response handshake (slave modport)
//   base_ram_*        base chip pins (data is a tristated inout)
//   ext_ram_*         ext chip pins  (data is a tristated inout)
// ---------------------------------------------------------------------------
module sram_req_executor #(
    parameter int RD_WAIT  = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 1,
    parameter int WR_HOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_req_executor_if.slave    req,
    inout  wire  [31:0]           base_ram_data,
    output logic [19:0]           base_ram_addr,
    output logic [3:0]            base_ram_be_n,
    output logic                  base_ram_ce_n,
    output logic                  base_ram_oe_n,
    output logic                  base_ram_we_n,
    inout  wire  [31:0]           ext_ram_data,
    output logic [19:0]           ext_ram_addr,
    output logic [3:0]            ext_ram_be_n,
    output logic                  ext_ram_ce_n,
    output logic                  ext_ram_oe_n,
    output logic                  ext_ram_we_n
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;

    // Latched request; rd flags are already cleared where a write overrides.
    logic               base_rd_r, base_wr_r, ext_rd_r, ext_wr_r;
    logic               base_rd_next_s, base_wr_next_s, ext_rd_next_s, ext_wr_next_s;
    logic [19:0]        base_addr_r, ext_addr_r;
    logic [31:0]        base_wdata_r, ext_wdata_r;
    logic               accept_s;
    logic               sample_s;

    // Registered pin drives and their next values.
    logic               base_ce_n_r, base_oe_n_r, base_we_n_r, base_drive_r;
    logic               ext_ce_n_r, ext_oe_n_r, ext_we_n_r, ext_drive_r;
    logic               base_ce_n_next_s, base_oe_n_next_s, base_we_n_next_s, base_drive_next_s;
    logic               ext_ce_n_next_s, ext_oe_n_next_s, ext_we_n_next_s, ext_drive_next_s;
    logic               active_next_s, wr_phase_next_s;

    logic               req_ready_r;
    logic               resp_valid_r;
    logic [31:0]        resp_base_rdata_r, resp_ext_rdata_r;

    // Next-state, counter and acceptance decode.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        accept_s       = 1'b0;
        sample_s       = 1'b0;
        base_rd_next_s = base_rd_r;
        base_wr_next_s = base_wr_r;
        ext_rd_next_s  = ext_rd_r;
        ext_wr_next_s  = ext_wr_r;
        case (state_r)
            ST_IDLE: begin
                if (req.req_valid && req_ready_r) begin
                    accept_s       = 1'b1;
                    base_wr_next_s = req.req_base_write_ce;
                    ext_wr_next_s  = req.req_ext_write_ce;
                    // A write on a chip wins over a read of the same chip.
                    base_rd_next_s = req.req_base_read_ce && !req.req_base_write_ce;
                    ext_rd_next_s  = req.req_ext_read_ce  && !req.req_ext_write_ce;
                    if (req.req_base_write_ce || req.req_ext_write_ce) begin
                        state_next_s = ST_WR_SETUP;
                        cnt_next_s   = CNT_W'(WR_SETUP - 1);
                    end else if (req.req_base_read_ce || req.req_ext_read_ce) begin
                        state_next_s = ST_RD;
                        cnt_next_s   = CNT_W'(RD_WAIT - 1);
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    sample_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_WR_PULSE;
                    cnt_next_s   = CNT_W'(WR_PULSE - 1);
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_WR_PULSE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_WR_HOLD;
                    cnt_next_s   = CNT_W'(WR_HOLD - 1);
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                // Reads sharing a write request are sampled at the very end.
                if (cnt_r == {CNT_W{1'b0}}) begin
                    sample_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pin values for the coming cycle, derived from the next state so the
    // registered pins line up exactly with the state they belong to.
    always_comb begin
        active_next_s   = (state_next_s == ST_RD) || (state_next_s == ST_WR_SETUP) ||
                          (state_next_s == ST_WR_PULSE) || (state_next_s == ST_WR_HOLD);
        wr_phase_next_s = (state_next_s == ST_WR_SETUP) || (state_next_s == ST_WR_PULSE) ||
                          (state_next_s == ST_WR_HOLD);

        base_ce_n_next_s  = !(active_next_s && (base_rd_next_s || base_wr_next_s));
        base_oe_n_next_s  = !(active_next_s && base_rd_next_s);
        base_we_n_next_s  = !((state_next_s == ST_WR_PULSE) && base_wr_next_s);
        base_drive_next_s = wr_phase_next_s && base_wr_next_s;

        ext_ce_n_next_s   = !(active_next_s && (ext_rd_next_s || ext_wr_next_s));
        ext_oe_n_next_s   = !(active_next_s && ext_rd_next_s);
        ext_we_n_next_s   = !((state_next_s == ST_WR_PULSE) && ext_wr_next_s);
        ext_drive_next_s  = wr_phase_next_s && ext_wr_next_s;
    end

    // State and phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request latch; addresses and write data change only at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_rd_r    <= 1'b0;
            base_wr_r    <= 1'b0;
            ext_rd_r     <= 1'b0;
            ext_wr_r     <= 1'b0;
            base_addr_r  <= 20'h00000;
            ext_addr_r   <= 20'h00000;
            base_wdata_r <= 32'h0000_0000;
            ext_wdata_r  <= 32'h0000_0000;
        end else begin
            base_rd_r <= base_rd_next_s;
            base_wr_r <= base_wr_next_s;
            ext_rd_r  <= ext_rd_next_s;
            ext_wr_r  <= ext_wr_next_s;
            if (accept_s) begin
                base_addr_r  <= req.req_addr_wdata_ce[103:84];
                ext_addr_r   <= req.req_addr_wdata_ce[83:64];
                base_wdata_r <= req.req_addr_wdata_ce[63:32];
                ext_wdata_r  <= req.req_addr_wdata_ce[31:0];
            end
        end
    end

    // SRAM control pins and bus-drive enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_ce_n_r  <= 1'b1;
            base_oe_n_r  <= 1'b1;
            base_we_n_r  <= 1'b1;
            base_drive_r <= 1'b0;
            ext_ce_n_r   <= 1'b1;
            ext_oe_n_r   <= 1'b1;
            ext_we_n_r   <= 1'b1;
            ext_drive_r  <= 1'b0;
        end else begin
            base_ce_n_r  <= base_ce_n_next_s;
            base_oe_n_r  <= base_oe_n_next_s;
            base_we_n_r  <= base_we_n_next_s;
            base_drive_r <= base_drive_next_s;
            ext_ce_n_r   <= ext_ce_n_next_s;
            ext_oe_n_r   <= ext_oe_n_next_s;
            ext_we_n_r   <= ext_we_n_next_s;
            ext_drive_r  <= ext_drive_next_s;
        end
    end

    // Handshake flags and captured read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r       <= 1'b1;
            resp_valid_r      <= 1'b0;
            resp_base_rdata_r <= 32'h0000_0000;
            resp_ext_rdata_r  <= 32'h0000_0000;
        end else begin
            req_ready_r  <= (state_next_s == ST_IDLE);
            resp_valid_r <= (state_next_s == ST_DONE);
            if (sample_s && base_rd_r) begin
                resp_base_rdata_r <= base_ram_data;
            end
            if (sample_s && ext_rd_r) begin
                resp_ext_rdata_r <= ext_ram_data;
            end
        end
    end

    assign req.req_ready       = req_ready_r;
    assign req.resp_valid      = resp_valid_r;
    assign req.resp_base_rdata = resp_base_rdata_r;
    assign req.resp_ext_rdata  = resp_ext_rdata_r;

    assign base_ram_data = base_drive_r ? base_wdata_r : 32'bz;
    assign base_ram_addr = base_addr_r;
    assign base_ram_be_n = 4'b0000;
    assign base_ram_ce_n = base_ce_n_r;
    assign base_ram_oe_n = base_oe_n_r;
    assign base_ram_we_n = base_we_n_r;

    assign ext_ram_data  = ext_drive_r ? ext_wdata_r : 32'bz;
    assign ext_ram_addr  = ext_addr_r;
    assign ext_ram_be_n  = 4'b0000;
    assign ext_ram_ce_n  = ext_ce_n_r;
    assign ext_ram_oe_n  = ext_oe_n_r;
    assign ext_ram_we_n  = ext_we_n_r;

endmodule

// File: tb/tb_sram_req_executor.sv
// ---------------------------------------------------------------------------
// tb_sram_req_executor
// Directed bench for sram_req_executor with default timing parameters.
// Small SRAM models (indexed by addr[7:0]) answer reads while ce_n/oe_n are
// low and capture writes while ce_n/we_n are low.
// ---------------------------------------------------------------------------
module tb_sram_req_executor;

    logic clk;
    logic rst;

    sram_req_executor_if req_if ();

    wire  [31:0] base_ram_data;
    logic [19:0] base_ram_addr;
    logic [3:0]  base_ram_be_n;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    wire  [31:0] ext_ram_data;
    logic [19:0] ext_ram_addr;
    logic [3:0]  ext_ram_be_n;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

    int tests_run;
    int tests_failed;

    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];

    // Per-cycle pin log of the last request, index 1 = first cycle after acceptance.
    logic        lg_bce [0:12];
    logic        lg_boe [0:12];
    logic        lg_bwe [0:12];
    logic        lg_ece [0:12];
    logic        lg_eoe [0:12];
    logic        lg_ewe [0:12];
    logic [31:0] lg_bdat [0:12];
    logic [31:0] lg_edat [0:12];
    logic [19:0] lg_badr [0:12];
    logic [19:0] lg_eadr [0:12];
    int          lat;

    sram_req_executor dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req_if),
        .base_ram_data (base_ram_data),
        .base_ram_addr (base_ram_addr),
        .base_ram_be_n (base_ram_be_n),
        .base_ram_ce_n (base_ram_ce_n),
        .base_ram_oe_n (base_ram_oe_n),
        .base_ram_we_n (base_ram_we_n),
        .ext_ram_data  (ext_ram_data),
        .ext_ram_addr  (ext_ram_addr),
        .ext_ram_be_n  (ext_ram_be_n),
        .ext_ram_ce_n  (ext_ram_ce_n),
        .ext_ram_oe_n  (ext_ram_oe_n),
        .ext_ram_we_n  (ext_ram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: drive on read, capture on write.
    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n && base_ram_we_n) ?
                           base_mem[base_ram_addr[7:0]] : 32'bz;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n && ext_ram_we_n) ?
                           ext_mem[ext_ram_addr[7:0]] : 32'bz;

    always @(negedge clk) begin
        if (!base_ram_ce_n && !base_ram_we_n) base_mem[base_ram_addr[7:0]] = base_ram_data;
        if (!ext_ram_ce_n && !ext_ram_we_n)   ext_mem[ext_ram_addr[7:0]]   = ext_ram_data;
    end

    task automatic drive_req(input logic brd, input logic bwr, input logic erd, input logic ewr,
                             input logic [19:0] ba, input logic [19:0] ea,
                             input logic [31:0] bw, input logic [31:0] ew);
        req_if.req_base_read_ce  = brd;
        req_if.req_base_write_ce = bwr;
        req_if.req_ext_read_ce   = erd;
        req_if.req_ext_write_ce  = ewr;
        req_if.req_addr_wdata_ce = {ba, ea, bw, ew};
        req_if.req_valid         = 1'b1;
    endtask

    // Issue one request, wait for acceptance, log pins until resp_valid (lat=0 on timeout).
    task automatic run_req(input logic brd, input logic bwr, input logic erd, input logic ewr,
                           input logic [19:0] ba, input logic [19:0] ea,
                           input logic [31:0] bw, input logic [31:0] ew);
        int  w;
        logic got;
        @(negedge clk);
        drive_req(brd, bwr, erd, ewr, ba, ea, bw, ew);
        w = 0;
        while (!req_if.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        lat = 0;
        if (!req_if.req_ready) begin
            req_if.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            got = 1'b0;
            for (int k = 1; k <= 12 && !got; k++) begin
                @(negedge clk);
                if (k == 1) req_if.req_valid = 1'b0;
                lg_bce[k] = base_ram_ce_n; lg_boe[k] = base_ram_oe_n; lg_bwe[k] = base_ram_we_n;
                lg_ece[k] = ext_ram_ce_n;  lg_eoe[k] = ext_ram_oe_n;  lg_ewe[k] = ext_ram_we_n;
                lg_bdat[k] = base_ram_data; lg_edat[k] = ext_ram_data;
                lg_badr[k] = base_ram_addr; lg_eadr[k] = ext_ram_addr;
                if (req_if.resp_valid) begin
                    got = 1'b1;
                    lat = k;
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests_run++;
        if ({req_if.req_ready, req_if.resp_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b want 10", {req_if.req_ready, req_if.resp_valid});
        end
        tests_run++;
        if ({req_if.resp_base_rdata, req_if.resp_ext_rdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h want 0", {req_if.resp_base_rdata, req_if.resp_ext_rdata});
        end
        tests_run++;
        if ({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n} !== 6'b111111) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 111111",
                     {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n});
        end
        tests_run++;
        if ({base_ram_addr, ext_ram_addr, base_ram_be_n, ext_ram_be_n} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_addr_be: got %h want 0", {base_ram_addr, ext_ram_addr, base_ram_be_n, ext_ram_be_n});
        end
    endtask

    task automatic test_base_read;
        int n;
        run_req(1'b1, 1'b0, 1'b0, 1'b0, 20'h00010, 20'h00000, 32'h0, 32'h0);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL rd_latency: got %0d want 3", lat);
        end
        n = 0;
        for (int k = 1; k <= lat; k++) if (!lg_bce[k] && !lg_boe[k] && lg_bwe[k]) n++;
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL rd_active_cycles: got %0d want 2", n);
        end
        tests_run++;
        if (lg_badr[1] !== 20'h00010) begin
            tests_failed++;
            $display("FAIL rd_addr: got %h want 00010", lg_badr[1]);
        end
        tests_run++;
        if (req_if.resp_base_rdata !== 32'hDEADBEEF || req_if.resp_ext_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_data: got %h/%h want deadbeef/00000000", req_if.resp_base_rdata, req_if.resp_ext_rdata);
        end
        n = 0;
        for (int k = 1; k <= lat; k++) if (!lg_ece[k]) n++;
        tests_run++;
        if (n !== 0) begin
            tests_failed++;
            $display("FAIL rd_ext_idle: got %0d ce cycles want 0", n);
        end
        @(negedge clk);
        tests_run++;
        if (req_if.resp_valid !== 1'b0 || req_if.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_pulse_width: got valid=%b ready=%b want 0/1", req_if.resp_valid, req_if.req_ready);
        end
    endtask

    task automatic test_ext_write;
        run_req(1'b0, 1'b0, 1'b0, 1'b1, 20'h00000, 20'hFFFFF, 32'h0, 32'h12345678);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL wr_latency: got %0d want 4", lat);
        end
        tests_run++;
        if ({lg_ece[1], lg_eoe[1], lg_ewe[1], lg_ece[2], lg_eoe[2], lg_ewe[2],
             lg_ece[3], lg_eoe[3], lg_ewe[3], lg_ece[4], lg_eoe[4], lg_ewe[4]} !== 12'b011_010_011_111) begin
            tests_failed++;
            $display("FAIL wr_ctrl_seq: got %b want 011010011111",
                     {lg_ece[1], lg_eoe[1], lg_ewe[1], lg_ece[2], lg_eoe[2], lg_ewe[2],
                      lg_ece[3], lg_eoe[3], lg_ewe[3], lg_ece[4], lg_eoe[4], lg_ewe[4]});
        end
        tests_run++;
        if (lg_edat[1] !== 32'h12345678 || lg_edat[2] !== 32'h12345678 || lg_edat[3] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL wr_data_window: got %h %h %h want 12345678 x3", lg_edat[1], lg_edat[2], lg_edat[3]);
        end
        tests_run++;
        if (lg_eadr[2] !== 20'hFFFFF || ext_mem[8'hFF] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL wr_mem: got addr %h mem %h want fffff/12345678", lg_eadr[2], ext_mem[8'hFF]);
        end
        tests_run++;
        if ({lg_bce[1], lg_bce[2], lg_bce[3]} !== 3'b111) begin
            tests_failed++;
            $display("FAIL wr_base_idle: got %b want 111", {lg_bce[1], lg_bce[2], lg_bce[3]});
        end
    endtask

    task automatic test_write_with_read;
        run_req(1'b0, 1'b1, 1'b1, 1'b0, 20'h00001, 20'h00002, 32'hA5A5A5A5, 32'h0);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL wrrd_latency: got %0d want 4", lat);
        end
        tests_run++;
        if ({lg_ece[1], lg_eoe[1], lg_ece[2], lg_eoe[2], lg_ece[3], lg_eoe[3], lg_eoe[4]} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL wrrd_ext_oe: got %b want 0000001",
                     {lg_ece[1], lg_eoe[1], lg_ece[2], lg_eoe[2], lg_ece[3], lg_eoe[3], lg_eoe[4]});
        end
        tests_run++;
        if (req_if.resp_ext_rdata !== 32'h0BADF00D || req_if.resp_base_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wrrd_rdata: got %h/%h want deadbeef/0badf00d", req_if.resp_base_rdata, req_if.resp_ext_rdata);
        end
        tests_run++;
        if (base_mem[8'h01] !== 32'hA5A5A5A5 || lg_bwe[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrrd_base_mem: got %h we=%b want a5a5a5a5/0", base_mem[8'h01], lg_bwe[2]);
        end
    endtask

    task automatic test_rw_override;
        int n;
        run_req(1'b1, 1'b1, 1'b0, 1'b0, 20'h00020, 20'h00000, 32'h5555AAAA, 32'h0);
        n = 0;
        for (int k = 1; k <= lat; k++) if (!lg_boe[k]) n++;
        tests_run++;
        if (n !== 0 || lat !== 4) begin
            tests_failed++;
            $display("FAIL ovr_oe: got %0d oe cycles lat %0d want 0/4", n, lat);
        end
        tests_run++;
        if (base_mem[8'h20] !== 32'h5555AAAA || req_if.resp_base_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL ovr_data: got mem %h rdata %h want 5555aaaa/deadbeef", base_mem[8'h20], req_if.resp_base_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int  k;
        int  w;
        logic got;
        run_req(1'b0, 1'b0, 1'b0, 1'b0, 20'h00033, 20'h00044, 32'h0, 32'h0);
        tests_run++;
        if (lat !== 1 || {lg_bce[1], lg_boe[1], lg_bwe[1], lg_ece[1], lg_eoe[1], lg_ewe[1]} !== 6'b111111) begin
            tests_failed++;
            $display("FAIL noop: got lat %0d pins %b want 1/111111", lat,
                     {lg_bce[1], lg_boe[1], lg_bwe[1], lg_ece[1], lg_eoe[1], lg_ewe[1]});
        end
        // No-op held with a read queued behind it: read waits for req_ready.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 20'h0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, 20'h00030, 20'h0, 32'h0, 32'h0);
        tests_run++;
        if ({req_if.resp_valid, req_if.req_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL busy_ready: got %b want 10", {req_if.resp_valid, req_if.req_ready});
        end
        @(negedge clk);
        tests_run++;
        if ({req_if.resp_valid, req_if.req_ready, base_ram_ce_n} !== 3'b011) begin
            tests_failed++;
            $display("FAIL ready_return: got %b want 011", {req_if.resp_valid, req_if.req_ready, base_ram_ce_n});
        end
        @(posedge clk);
        k = 0;
        got = 1'b0;
        w = 0;
        while (!got && w < 12) begin
            @(negedge clk);
            req_if.req_valid = 1'b0;
            w++;
            if (req_if.resp_valid) begin
                got = 1'b1;
                k = w;
            end
        end
        tests_run++;
        if (k !== 3 || req_if.resp_base_rdata !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL queued_read: got lat %0d data %h want 3/cafef00d", k, req_if.resp_base_rdata);
        end
    endtask

    task automatic test_reset_mid_write;
        logic seen;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 20'h00040, 20'h0, 32'h77778888, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (base_ram_we_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_before_rst: got we_n %b want 0", base_ram_we_n);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, req_if.req_ready, req_if.resp_valid} !== 5'b11110) begin
            tests_failed++;
            $display("FAIL async_rst: got %b want 11110",
                     {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, req_if.req_ready, req_if.resp_valid});
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (req_if.resp_valid) seen = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (req_if.resp_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_no_resp: got resp_valid %b want 0", seen);
        end
        run_req(1'b1, 1'b0, 1'b0, 1'b0, 20'h00010, 20'h0, 32'h0, 32'h0);
        tests_run++;
        if (lat !== 3 || req_if.resp_base_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL read_after_rst: got lat %0d data %h want 3/deadbeef", lat, req_if.resp_base_rdata);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) begin
            base_mem[i] = 32'h0;
            ext_mem[i]  = 32'h0;
        end
        base_mem[8'h10] = 32'hDEADBEEF;
        base_mem[8'h30] = 32'hCAFEF00D;
        ext_mem[8'h02]  = 32'h0BADF00D;
        req_if.req_valid         = 1'b0;
        req_if.req_base_read_ce  = 1'b0;
        req_if.req_base_write_ce = 1'b0;
        req_if.req_ext_read_ce   = 1'b0;
        req_if.req_ext_write_ce  = 1'b0;
        req_if.req_addr_wdata_ce = 104'h0;
        rst = 1'b1;
        test_reset;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_base_read;
        test_ext_write;
        test_write_with_read;
        test_rw_override;
        test_back_to_back;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
